// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: registered grant, owner muxing onto the slave side, round-robin with burst limit.
// Optional macro DBUS_CPU_PRIO_EN: master 0 wins ties, preempts master 1 and has no burst limit.
module dbus_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_byteen,
    input  logic [31:0] s_rdata
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BEAT_MAX  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

`ifdef DBUS_CPU_PRIO_EN
    localparam bit CPU_PRIO = 1'b1;
`else
    localparam bit CPU_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;
    typedef enum logic {LAST_M0, LAST_M1} last_t;

    owner_t        owner;
    last_t         last;
    logic [BW-1:0] beats;
    logic [BW-1:0] beats_inc;
    logic          at_limit;
    logic          m0_beat;
    logic          m1_beat;

    assign beats_inc = (beats == BEAT_MAX) ? beats : beats + 1'b1;
    // True when the beat in progress is the owner's MAX_BURST-th (or later, once saturated).
    assign at_limit  = (beats >= BEAT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner <= OWN_NONE;
            last  <= LAST_M1;
            beats <= '0;
        end else begin
            case (owner)
                OWN_NONE: begin
                    beats <= '0;
                    if (m0_req && (!m1_req || CPU_PRIO || last == LAST_M1)) begin
                        owner <= OWN_M0;
                        last  <= LAST_M0;
                    end else if (m1_req) begin
                        owner <= OWN_M1;
                        last  <= LAST_M1;
                    end
                end
                OWN_M0: begin
                    if (!m0_req) begin
                        beats <= '0;
                        if (m1_req) begin
                            owner <= OWN_M1;
                            last  <= LAST_M1;
                        end else begin
                            owner <= OWN_NONE;
                        end
                    end else if (m1_req && at_limit && !CPU_PRIO) begin
                        owner <= OWN_M1;
                        last  <= LAST_M1;
                        beats <= '0;
                    end else begin
                        beats <= beats_inc;
                    end
                end
                OWN_M1: begin
                    if (!m1_req) begin
                        beats <= '0;
                        if (m0_req) begin
                            owner <= OWN_M0;
                            last  <= LAST_M0;
                        end else begin
                            owner <= OWN_NONE;
                        end
                    end else if (m0_req && (at_limit || CPU_PRIO)) begin
                        owner <= OWN_M0;
                        last  <= LAST_M0;
                        beats <= '0;
                    end else begin
                        beats <= beats_inc;
                    end
                end
                default: begin
                    owner <= OWN_NONE;
                    beats <= '0;
                end
            endcase
        end
    end

    assign m0_gnt  = (owner == OWN_M0);
    assign m1_gnt  = (owner == OWN_M1);
    assign m0_beat = m0_gnt & m0_req;
    assign m1_beat = m1_gnt & m1_req;

    always_comb begin
        s_addr   = '0;
        s_wdata  = '0;
        s_byteen = '0;
        if (m0_gnt) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
        end else if (m1_gnt) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end
        // Byte enables only on a real beat so a granted but idle master never writes.
        if (m0_beat) begin
            s_byteen = m0_byteen;
        end else if (m1_beat) begin
            s_byteen = m1_byteen;
        end
    end

    assign m0_rdata = m0_gnt ? s_rdata : '0;
    assign m1_rdata = m1_gnt ? s_rdata : '0;

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter for the shared data bus that reaches data memory and the T0/T1 timer windows. Master 0 is the CPU data port; master 1 is a DMA/debug requester. The block grants the bus to one owner at a time and muxes that owner's address, write data and byte enables onto the slave side. Read data is routed back only to the owner. It sits between the CPU data port and the existing address-decode/bridge logic, and it replaces the direct CPU-to-bus connection.

## Interface
- `MAX_BURST`, default 4: maximum number of consecutive beats an owner keeps while the other master is requesting. Must be ≥1.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `m0_req`, `m1_req` input 1: master requests the bus; held high until the master has no more beats.
- `m0_addr`, `m1_addr` input 32: byte address of the beat.
- `m0_wdata`, `m1_wdata` input 32: write data.
- `m0_byteen`, `m1_byteen` input 4: byte write enables; 0 means a read.
- `m0_gnt`, `m1_gnt` output 1: registered grant; at most one is high.
- `m0_rdata`, `m1_rdata` output 32: `s_rdata` when that master owns the bus, else 0.
- `s_addr` output 32: owner's `addr`, else 0.
- `s_wdata` output 32: owner's `wdata`, else 0.
- `s_byteen` output 4: owner's `byteen` on a beat, else 0.
- `s_rdata` input 32: slave read data, valid in the same cycle as `s_addr`.

## Operation
- State:
  - `owner` ∈ {NONE, M0, M1}.
  - `last`: most recently served master.
  - `beats`: counter of `$clog2(MAX_BURST+1)` bits, saturating at MAX_BURST.
- Beat: a cycle in which `mX_gnt & mX_req` holds for the owner.
  - Slave signals mirror the owner combinationally.
  - `s_byteen` passes through only on a beat, so a granted master with `req` low writes nothing.
- Next-owner decision at every edge, where "other" is the non-owner's request:
  - NONE, single request: that master becomes owner.
  - NONE, both requesting: the master ≠ `last` wins (round-robin).
  - Owner with `req` low: switch to the other master if it is requesting, else NONE.
  - Owner with `req` high, other requesting, and `beats` reaching MAX_BURST on this beat: switch to the other master.
  - Otherwise the owner is kept.
- On every ownership change: `beats` ← 0 and `last` ← the new owner.
- `beats` increments on each beat of the current owner.
- Handoff A→B is direct: B is granted on the cycle after A's last beat, with no idle cycle.
- Reset values: `owner`=NONE, `beats`=0, `last`=M1 (so M0 wins the first tie). All outputs are 0.

## Timing
- Grant latency: a request rising in cycle n with the bus free gives `gnt` high in cycle n+1. The first beat is in cycle n+1.
- Read data is combinational from `s_rdata` within the beat cycle, with zero added latency.
- Release: a master dropping `req` in cycle n loses `gnt` at n+1. Cycle n is a non-beat with `s_byteen`=0.
- Burst limit with contention: the owner gets exactly MAX_BURST beats, then the other master is granted on the next cycle.
  - An uncontended owner keeps the bus indefinitely; `beats` saturates.
- Simultaneous events, when the owner drops `req` in the same cycle the other master raises it: the other master is granted next cycle.
- Reset mid-burst: `gnt`, `s_byteen` and `s_addr` go to 0 immediately, without waiting for a clock edge. No partial write is issued after the reset assertion.

## Configuration
- `DBUS_CPU_PRIO_EN` defined:
  - M0 wins every tie from NONE.
  - When M1 owns and `m0_req` is high, M1 loses the bus at the next edge regardless of `beats`.
  - M0 is never limited by MAX_BURST.
- `DBUS_CPU_PRIO_EN` undefined: round-robin plus MAX_BURST fairness, as described above.

## Test plan
- Reset then both requests in cycle 1 → `m0_gnt`=1 in cycle 2, `m1_gnt`=0. After M0 drops `req`, `m1_gnt`=1 the next cycle.
- M1 alone writes `0x0000_7F00` (T0 window), `byteen`=4'hF, `wdata`=9 → `s_addr`=0x7F00, `s_byteen`=4'hF, `s_wdata`=9 in the grant cycle. `m0_rdata`=0 throughout.
- MAX_BURST=4, M0 holding `req`, M1 requesting from cycle 2 → M0 gets exactly 4 beats. `m1_gnt` rises the following cycle.
- Owner M0 with `req` low for one cycle while still granted, `byteen`=4'hF → `s_byteen`=0 that cycle; bus goes to NONE.
- `reset` asserted mid-way through an M1 burst → `m1_gnt`, `s_byteen` and `s_addr` are 0 in the same cycle. After release, a tie goes to M0.
- With `DBUS_CPU_PRIO_EN`: M1 owns, `m0_req` rises at beat 1 → `m0_gnt`=1 at the next edge, and M1 has completed only 1 beat.
